// File: rtl/regfile_read_port.sv
// regfile_read_port
//
// Dual-read, single-write register file with flop storage and a registered,
// valid/ready handshaked read port. The writeback stage writes one register per
// cycle without back-pressure; the decode stage reads two operands per request
// and gets them one cycle after the request is accepted.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN  defined   -> write-first: an accepted read of the address
//                                   being written in the same cycle captures the
//                                   incoming write data.
//                      undefined -> read-first: the read captures the pre-write
//                                   contents.
//
// Parameters:
//   WIDTH       data width of each register
//   DEPTH_LOG2  address width; 2**DEPTH_LOG2 registers
//
// Ports:
//   clk               clock, all state updates on the rising edge
//   reset             asynchronous active-low reset
//   ctrl_writeEnable  write strobe
//   ctrl_writeReg     write address
//   data_writeReg     write data
//   rd_req_valid      read request present
//   rd_req_ready      read request accepted when valid & ready
//   ctrl_readRegA     source A address
//   ctrl_readRegB     source B address
//   rd_out_valid      data_readRegA/B hold valid operands
//   rd_out_ready      consumer accepts the output
//   data_readRegA     registered operand A
//   data_readRegB     registered operand B

module regfile_read_port #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ctrl_writeEnable,
  input  logic [DEPTH_LOG2-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]      data_writeReg,
  input  logic                  rd_req_valid,
  output logic                  rd_req_ready,
  input  logic [DEPTH_LOG2-1:0] ctrl_readRegA,
  input  logic [DEPTH_LOG2-1:0] ctrl_readRegB,
  output logic                  rd_out_valid,
  input  logic                  rd_out_ready,
  output logic [WIDTH-1:0]      data_readRegA,
  output logic [WIDTH-1:0]      data_readRegB
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  // Storage for registers 1..DEPTH-1; register 0 has no flops at all.
  logic [WIDTH-1:0] r_mem [1:DEPTH-1];

  // Full-depth view with register 0 tied to zero, so reads index uniformly.
  logic [WIDTH-1:0] w_mem [DEPTH];

  logic             w_wr_en;
  logic             w_accept;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_data_a;
  logic [WIDTH-1:0] r_data_b;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------

  // Writes to register 0 are dropped here so neither storage nor bypass sees them.
  assign w_wr_en = ctrl_writeEnable && (ctrl_writeReg != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[ctrl_writeReg] <= data_writeReg;
    end
  end

  always_comb begin
    w_mem[0] = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_mem[i] = r_mem[i];
    end
  end

  // ---------------------------------------------------------------------------
  // Read operand selection
  // ---------------------------------------------------------------------------

  always_comb begin
    w_rd_a = w_mem[ctrl_readRegA];
    w_rd_b = w_mem[ctrl_readRegB];
`ifdef REGFILE_BYPASS_EN
    // Write-first: forward the in-flight write. w_wr_en already excludes r0.
    if (w_wr_en && (ctrl_writeReg == ctrl_readRegA)) begin
      w_rd_a = data_writeReg;
    end
    if (w_wr_en && (ctrl_writeReg == ctrl_readRegB)) begin
      w_rd_b = data_writeReg;
    end
`else
    // Read-first: the register contents before this edge's write are captured.
`endif
  end

  // ---------------------------------------------------------------------------
  // Handshake and output stage
  // ---------------------------------------------------------------------------

  // One-deep output stage: a new request fits if the slot is empty or draining.
  assign rd_req_ready = !r_out_valid || rd_out_ready;
  assign w_accept     = rd_req_valid && rd_req_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_data_a    <= '0;
      r_data_b    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_data_a    <= w_rd_a;
      r_data_b    <= w_rd_b;
    end else if (rd_out_ready) begin
      // Output consumed with nothing to replace it; data keeps its last value.
      r_out_valid <= 1'b0;
    end
  end

  assign rd_out_valid  = r_out_valid;
  assign data_readRegA = r_data_a;
  assign data_readRegB = r_data_b;

endmodule

// File: tb/tb_regfile_read_port.sv
module tb_regfile_read_port;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned DEPTH_LOG2 = 5;

  logic                  clk;
  logic                  reset;
  logic                  ctrl_writeEnable;
  logic [DEPTH_LOG2-1:0] ctrl_writeReg;
  logic [WIDTH-1:0]      data_writeReg;
  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [DEPTH_LOG2-1:0] ctrl_readRegA;
  logic [DEPTH_LOG2-1:0] ctrl_readRegB;
  logic                  rd_out_valid;
  logic                  rd_out_ready;
  logic [WIDTH-1:0]      data_readRegA;
  logic [WIDTH-1:0]      data_readRegB;

  int checks = 0;
  int errors = 0;

  regfile_read_port #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .rd_req_valid     (rd_req_valid),
    .rd_req_ready     (rd_req_ready),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .rd_out_valid     (rd_out_valid),
    .rd_out_ready     (rd_out_ready),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = a;
    data_writeReg    = d;
    tick();
    ctrl_writeEnable = 1'b0;
  endtask

  task automatic test_reset();
    reset            = 1'b0;
    rd_req_valid     = 1'b1;
    rd_out_ready     = 1'b1;
    ctrl_readRegA    = 5'd1;
    ctrl_readRegB    = 5'd2;
    ctrl_writeEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ctrl_writeReg = 5'(i + 1);
      data_writeReg = $urandom;
      tick();
    end
    ctrl_writeEnable = 1'b0;
    rd_req_valid     = 1'b0;
    checks++;
    if (rd_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b exp 0", rd_out_valid);
    end
    checks++;
    if (data_readRegA !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_a got %h exp 00000000", data_readRegA);
    end
    checks++;
    if (data_readRegB !== 32'h0) begin
      errors++;
      $display("FAIL reset_data_b got %h exp 00000000", data_readRegB);
    end
    reset = 1'b1;
    tick();
    for (int i = 1; i < 32; i++) begin
      rd_req_valid  = 1'b1;
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(32 - i);
      tick();
      checks++;
      if (rd_out_valid !== 1'b1 || data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
        errors++;
        $display("FAIL reset_clear_r%0d got v=%b a=%h b=%h exp v=1 a=0 b=0",
                 i, rd_out_valid, data_readRegA, data_readRegB);
      end
    end
    rd_req_valid = 1'b0;
    tick();
    checks++;
    if (rd_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_valid got %b exp 0", rd_out_valid);
    end
  endtask

  task automatic test_write_read();
    write_reg(5'd5, 32'hDEADBEEF);
    rd_req_valid  = 1'b1;
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd0;
    tick();
    rd_req_valid = 1'b0;
    checks++;
    if (rd_out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wr_rd_valid got %b exp 1", rd_out_valid);
    end
    checks++;
    if (data_readRegA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_a got %h exp deadbeef", data_readRegA);
    end
    checks++;
    if (data_readRegB !== 32'h0) begin
      errors++;
      $display("FAIL wr_rd_b got %h exp 00000000", data_readRegB);
    end
    // Output drained: valid drops, data holds.
    tick();
    checks++;
    if (rd_out_valid !== 1'b0 || data_readRegA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL drain_hold got v=%b a=%h exp v=0 a=deadbeef", rd_out_valid, data_readRegA);
    end
  endtask

  task automatic test_r0();
    write_reg(5'd0, 32'hFFFFFFFF);
    rd_req_valid  = 1'b1;
    ctrl_readRegA = 5'd0;
    ctrl_readRegB = 5'd5;
    tick();
    checks++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL r0_read got a=%h b=%h exp a=00000000 b=deadbeef",
               data_readRegA, data_readRegB);
    end
    // Same-cycle write to r0 with read of r0: never forwarded.
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'h55AA55AA;
    ctrl_readRegA    = 5'd0;
    ctrl_readRegB    = 5'd0;
    tick();
    ctrl_writeEnable = 1'b0;
    rd_req_valid     = 1'b0;
    checks++;
    if (data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      errors++;
      $display("FAIL r0_bypass got a=%h b=%h exp 0 0", data_readRegA, data_readRegB);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] exp_a;
`ifdef REGFILE_BYPASS_EN
    exp_a = 32'h12345678;
`else
    exp_a = 32'h00000001;
`endif
    write_reg(5'd7, 32'h00000001);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd7;
    data_writeReg    = 32'h12345678;
    rd_req_valid     = 1'b1;
    ctrl_readRegA    = 5'd7;
    ctrl_readRegB    = 5'd7;
    tick();
    ctrl_writeEnable = 1'b0;
    checks++;
    if (data_readRegA !== exp_a) begin
      errors++;
      $display("FAIL hazard_a got %h exp %h", data_readRegA, exp_a);
    end
    checks++;
    if (data_readRegB !== exp_a) begin
      errors++;
      $display("FAIL hazard_b_same_addr got %h exp %h", data_readRegB, exp_a);
    end
    tick();
    rd_req_valid = 1'b0;
    checks++;
    if (data_readRegA !== 32'h12345678) begin
      errors++;
      $display("FAIL hazard_next got %h exp 12345678", data_readRegA);
    end
  endtask

  task automatic test_backpressure();
    write_reg(5'd3, 32'h000000AA);
    rd_out_ready  = 1'b0;
    rd_req_valid  = 1'b1;
    ctrl_readRegA = 5'd3;
    ctrl_readRegB = 5'd7;
    tick();
    checks++;
    if (rd_out_valid !== 1'b1 || data_readRegA !== 32'hAA) begin
      errors++;
      $display("FAIL bp_first got v=%b a=%h exp v=1 a=000000aa", rd_out_valid, data_readRegA);
    end
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = 5'd3;
    data_writeReg    = 32'h000000BB;
    ctrl_readRegB    = 5'd5;
    checks++;
    if (rd_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_req_ready got %b exp 0", rd_req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      ctrl_writeEnable = 1'b0;
      checks++;
      if (rd_out_valid !== 1'b1 || data_readRegA !== 32'hAA || data_readRegB !== 32'h12345678
          || rd_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got v=%b a=%h b=%h rdy=%b exp v=1 a=000000aa b=12345678 rdy=0",
                 i, rd_out_valid, data_readRegA, data_readRegB, rd_req_ready);
      end
    end
    rd_out_ready = 1'b1;
    #1;
    checks++;
    if (rd_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready got %b exp 1", rd_req_ready);
    end
    tick();
    rd_req_valid = 1'b0;
    checks++;
    if (rd_out_valid !== 1'b1 || data_readRegA !== 32'hBB || data_readRegB !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL bp_after got v=%b a=%h b=%h exp v=1 a=000000bb b=deadbeef",
               rd_out_valid, data_readRegA, data_readRegB);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals[0] = 32'h0000000A;
    vals[1] = 32'h0000000B;
    vals[2] = 32'h0000000C;
    write_reg(5'd10, vals[0]);
    write_reg(5'd11, vals[1]);
    write_reg(5'd12, vals[2]);
    rd_out_ready = 1'b1;
    rd_req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ctrl_readRegA = 5'(10 + i);
      ctrl_readRegB = 5'(12 - i);
      #1;
      checks++;
      if (rd_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d got %b exp 1", i, rd_req_ready);
      end
      tick();
      checks++;
      if (rd_out_valid !== 1'b1 || data_readRegA !== vals[i] || data_readRegB !== vals[2 - i]) begin
        errors++;
        $display("FAIL b2b%0d got v=%b a=%h b=%h exp v=1 a=%h b=%h",
                 i, rd_out_valid, data_readRegA, data_readRegB, vals[i], vals[2 - i]);
      end
    end
    rd_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    write_reg(5'd9, 32'h00000099);
    rd_out_ready  = 1'b0;
    rd_req_valid  = 1'b1;
    ctrl_readRegA = 5'd9;
    ctrl_readRegB = 5'd9;
    tick();
    rd_req_valid = 1'b0;
    checks++;
    if (rd_out_valid !== 1'b1 || data_readRegA !== 32'h99) begin
      errors++;
      $display("FAIL ar_stall got v=%b a=%h exp v=1 a=00000099", rd_out_valid, data_readRegA);
    end
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (rd_out_valid !== 1'b0 || data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      errors++;
      $display("FAIL ar_immediate got v=%b a=%h b=%h exp v=0 a=0 b=0",
               rd_out_valid, data_readRegA, data_readRegB);
    end
    tick();
    tick();
    reset        = 1'b1;
    rd_out_ready = 1'b1;
    tick();
    rd_req_valid  = 1'b1;
    ctrl_readRegA = 5'd9;
    ctrl_readRegB = 5'd5;
    tick();
    rd_req_valid = 1'b0;
    checks++;
    if (rd_out_valid !== 1'b1 || data_readRegA !== 32'h0 || data_readRegB !== 32'h0) begin
      errors++;
      $display("FAIL ar_cleared got v=%b a=%h b=%h exp v=1 a=0 b=0",
               rd_out_valid, data_readRegA, data_readRegB);
    end
  endtask

  initial begin
    reset            = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    rd_req_valid     = 1'b0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    rd_out_ready     = 1'b1;
    #2;
    test_reset();
    test_write_read();
    test_r0();
    test_hazard();
    test_backpressure();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
